hb_up_packetizer: RTL and testbench

- Sits directly downstream of the time manager (TimeMgr).
- On each heartbeat pulse, captures the current time_elapsed value and serializes it into fixed-width upstream words. Each word carries a route code, a word index and a payload slice.
- Output is a valid/ack channel toward the upstream (to-PC) merge tree, so the PC learns FPGA time.

---
 rtl/hb_up_packetizer.sv | 96 +++++++++
 tb/tb_hb_up_packetizer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hb_up_packetizer.sv
// rtl/hb_up_packetizer.sv - heartbeat time capture serialized into {code, idx, payload} upstream words
// Holds one captured time; a pulse landing on the final-word transfer edge chains straight into the next packet.
module hb_up_packetizer #(
   parameter int Ntime    = 48,
   parameter int Npayload = 16,
   parameter int Ncode    = 4,
   parameter int HBCode   = 11,
   parameter int Nidx     = 2,
   parameter int Ndrop    = 8
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              send_HB_up_pulse,
   input  logic [Ntime-1:0]                  time_elapsed,
   output logic                              out_v,
   input  logic                              out_a,
   output logic [Ncode+Nidx+Npayload-1:0]    out_d,
   output logic                              busy,
   output logic [Ndrop-1:0]                  hb_dropped
);

   localparam int Nwords = (Ntime + Npayload - 1) / Npayload;
   localparam int Ncap   = Nwords * Npayload;
   localparam logic [Nidx-1:0]  LAST_IDX = Nidx'(Nwords - 1);
   localparam logic [Ncode-1:0] HB_CODE  = Ncode'(HBCode);

   typedef enum logic {IDLE, SEND} state_t;

   state_t            state_q, state_d;
   logic [Ncap-1:0]   cap_q, cap_d;
   logic [Nidx-1:0]   idx_q, idx_d;
   logic [Ndrop-1:0]  drop_q, drop_d;

   logic              xfer;
   logic              last_xfer;
   logic [Npayload-1:0] payload;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cap_q   <= '0;
         idx_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         idx_q   <= idx_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cap_d     = cap_q;
      idx_d     = idx_q;
      drop_d    = drop_q;
      xfer      = (state_q == SEND) && out_a;
      last_xfer = xfer && (idx_q == LAST_IDX);
      case (state_q)
         IDLE: begin
            if (send_HB_up_pulse) begin
               cap_d   = Ncap'(time_elapsed);
               idx_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (last_xfer) begin
               idx_d = '0;
               if (send_HB_up_pulse) begin
                  cap_d = Ncap'(time_elapsed);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               if (xfer) begin
                  idx_d = idx_q + 1'b1;
               end
               // Any pulse not coinciding with the final transfer is lost; count it, never wrap.
               if (send_HB_up_pulse && (drop_q != {Ndrop{1'b1}})) begin
                  drop_d = drop_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs derive only from flops, so out_a never reaches out_v/out_d combinationally.
   assign payload    = cap_q[int'(idx_q) * Npayload +: Npayload];
   assign out_v      = (state_q == SEND);
   assign busy       = (state_q == SEND);
   assign out_d      = (state_q == SEND) ? {HB_CODE, idx_q, payload} : '0;
   assign hb_dropped = drop_q;

endmodule

// File: tb/tb_hb_up_packetizer.sv
// tb/tb_hb_up_packetizer.sv - scoreboard bench for hb_up_packetizer
module tb_hb_up_packetizer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        pulse = 1'b0;
   logic [47:0] t_el = '0;
   logic        out_v;
   logic        out_a = 1'b0;
   logic [21:0] out_d;
   logic        busy;
   logic [7:0]  drop;

   logic        s_pulse = 1'b0;
   logic        s_v;
   logic [21:0] s_d;
   logic        s_busy;
   logic [1:0]  s_drop;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [21:0] exp_q[$];
   logic        stall = 1'b0;
   logic [21:0] held = '0;

   hb_up_packetizer u_dut (
      .clk              (clk),
      .reset            (reset),
      .send_HB_up_pulse (pulse),
      .time_elapsed     (t_el),
      .out_v            (out_v),
      .out_a            (out_a),
      .out_d            (out_d),
      .busy             (busy),
      .hb_dropped       (drop)
   );

   hb_up_packetizer #(.Ndrop(2)) u_sat (
      .clk              (clk),
      .reset            (reset),
      .send_HB_up_pulse (s_pulse),
      .time_elapsed     (t_el),
      .out_v            (s_v),
      .out_a            (1'b0),
      .out_d            (s_d),
      .busy             (s_busy),
      .hb_dropped       (s_drop)
   );

   always #5 clk = ~clk;

   function automatic logic [21:0] hbw(input logic [47:0] t, input int i);
      logic [1:0] ix;
      ix = 2'(i);
      return {4'hB, ix, t[i*16 +: 16]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      n_cmp++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   task automatic push_pkt(input logic [47:0] t);
      for (int i = 0; i < 3; i++) exp_q.push_back(hbw(t, i));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fire(input logic [47:0] t);
      t_el  = t;
      pulse = 1'b1;
      tick();
      pulse = 1'b0;
   endtask

   task automatic drain(input bit rnd);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         if (rnd) out_a = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      check("drain_done", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      out_a = 1'b1;
   endtask

   // Monitor: a word is consumed at the posedge following a negedge that sees out_v && out_a.
   always @(negedge clk) begin
      if (!reset) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            check("stall_valid", 64'(out_v), 64'd1);
            check("stall_data", 64'(out_d), 64'(held));
         end
         if (out_v && out_a) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 64'(out_d), 64'h3FFFFFFFFFFFFF);
            end else begin
               check("word", 64'(out_d), 64'(exp_q.pop_front()));
            end
         end
         stall = out_v && !out_a;
         held  = out_d;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] tm_time;

      // Reset state
      tick();
      check("rst_out_v", 64'(out_v), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_drop", 64'(drop), 64'd0);
      check("rst_out_d", 64'(out_d), 64'd0);
      reset = 1'b1;
      tick();

      // Basic packet
      out_a = 1'b1;
      exp_q.push_back(22'h2C9ABC);
      exp_q.push_back(22'h2D5678);
      exp_q.push_back(22'h2E1234);
      fire(48'h123456789ABC);
      check("basic_first_valid", 64'(out_v), 64'd1);
      drain(0);
      tick();
      check("basic_out_v", 64'(out_v), 64'd0);
      check("basic_busy", 64'(busy), 64'd0);
      check("basic_drop", 64'(drop), 64'd0);

      // Backpressure: 5-cycle stall then random ack
      out_a = 1'b0;
      exp_q.push_back(22'h2C9ABC);
      exp_q.push_back(22'h2D5678);
      exp_q.push_back(22'h2E1234);
      fire(48'h123456789ABC);
      repeat (5) tick();
      drain(1);
      tick();
      check("bp_idle", 64'(out_v), 64'd0);

      // Same-edge accept on final transfer
      out_a = 1'b1;
      push_pkt(48'hAAAABBBBCCCC);
      exp_q.push_back(22'h2C0001);
      exp_q.push_back(22'h2D0000);
      exp_q.push_back(22'h2E0000);
      fire(48'hAAAABBBBCCCC);
      check("se_v0", 64'(out_v), 64'd1);
      tick();
      check("se_v1", 64'(out_v), 64'd1);
      tick();
      check("se_v2", 64'(out_v), 64'd1);
      fire(48'h000000000001);
      check("se_v3", 64'(out_v), 64'd1);
      check("se_busy", 64'(busy), 64'd1);
      check("se_idx0", 64'(out_d), 64'h2C0001);
      drain(0);
      check("se_drop", 64'(drop), 64'd0);

      // Drops while busy
      out_a = 1'b0;
      push_pkt(48'h0000DEADBEEF);
      fire(48'h0000DEADBEEF);
      repeat (3) begin
         tick();
         fire(48'hFFFFFFFFFFFF);
      end
      check("drop_count", 64'(drop), 64'd3);
      check("drop_busy", 64'(busy), 64'd1);
      out_a = 1'b1;
      drain(0);

      // Saturation on the 2-bit counter instance
      s_pulse = 1'b1;
      tick();
      s_pulse = 1'b0;
      repeat (5) begin
         tick();
         s_pulse = 1'b1;
         tick();
         s_pulse = 1'b0;
      end
      check("sat_drop", 64'(s_drop), 64'd3);
      check("sat_busy", 64'(s_busy), 64'd1);

      // Reset mid-packet after word 1
      out_a = 1'b1;
      exp_q.push_back(hbw(48'h111122223333, 0));
      exp_q.push_back(hbw(48'h111122223333, 1));
      fire(48'h111122223333);
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("mrst_out_v", 64'(out_v), 64'd0);
      check("mrst_busy", 64'(busy), 64'd0);
      check("mrst_drop", 64'(drop), 64'd0);
      check("mrst_out_d", 64'(out_d), 64'd0);
      check("mrst_sat_drop", 64'(s_drop), 64'd0);
      check("mrst_queue", 64'(exp_q.size()), 64'd0);
      tick();
      reset = 1'b1;
      tick();
      check("mrst_idle", 64'(out_v), 64'd0);
      exp_q.push_back(22'h2C0BAD);
      exp_q.push_back(22'h2D0000);
      exp_q.push_back(22'h2E0000);
      fire(48'h000000000BAD);
      drain(0);

      // TimeMgr-style drive: unit_len=8, heartbeat every 4 units
      tm_time = '0;
      out_a = 1'b1;
      for (int c = 1; c <= 128; c++) begin
         if (c % 8 == 0) tm_time = tm_time + 48'd1;
         t_el = tm_time;
         if ((c % 8 == 0) && (tm_time[1:0] == 2'b00)) begin
            check("int_prev_done", 64'(exp_q.size()), 64'd0);
            push_pkt(tm_time);
            pulse = 1'b1;
         end else begin
            pulse = 1'b0;
         end
         tick();
      end
      pulse = 1'b0;
      drain(0);
      check("int_drop", 64'(drop), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
